// File: rtl/regfile_dump.sv
// Sequential regfile read-out engine: walks a wrapping register range via one async read port
// and streams (index, value) beats over valid/ready. Optional checksum beat: REGFILE_DUMP_CHECKSUM_EN.
module regfile_dump #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic [ADDR_W-1:0] ra,
  input  logic [DATA_W-1:0] rd,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] dout_idx,
  output logic              dout_last,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_CSUM, S_DONE} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_DONE} state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ra_q, ra_d;
  logic [ADDR_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                dlast_q, dlast_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                hshake_c;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q, csum_d;
`endif

  assign hshake_c = valid_q && dout_ready;

  // State and beat registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      last_q  <= '0;
      dout_q  <= '0;
      idx_q   <= '0;
      dlast_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      idx_q   <= idx_d;
      dlast_q <= dlast_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    last_d  = last_q;
    dout_d  = dout_q;
    idx_d   = idx_q;
    dlast_d = dlast_q;
    valid_d = valid_q;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          ra_d    = first_reg;
          last_d  = last_reg;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      S_READ: begin
        dout_d  = rd;
        idx_d   = ra_q;
        valid_d = 1'b1;
        state_d = S_SEND;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        dlast_d = 1'b0;
        csum_d  = csum_q + rd;
`else
        dlast_d = (ra_q == last_q);
`endif
      end
      S_SEND: begin
        if (hshake_c) begin
          valid_d = 1'b0;
          dlast_d = 1'b0;
          if (ra_q != last_q) begin
            ra_d    = ra_q + ADDR_W'(1);
            state_d = S_READ;
          end else begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      // First cycle loads the checksum beat, then hold until accepted
      S_CSUM: begin
        if (!valid_q) begin
          dout_d  = csum_q;
          idx_d   = '0;
          dlast_d = 1'b1;
          valid_d = 1'b1;
        end else if (hshake_c) begin
          valid_d = 1'b0;
          dlast_d = 1'b0;
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        dlast_d = 1'b0;
      end
    endcase

    // Abort overrides everything, including a same-cycle handshake
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      dlast_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign ra         = ra_q;
  assign dout       = dout_q;
  assign dout_idx   = idx_q;
  assign dout_last  = dlast_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Sequential read-out engine for the 32×64-bit register file. It walks a programmed register range through one regfile asynchronous read port and streams each value, tagged with its register index, over a valid/ready interface. It sits beside the datapath as a debug/test reader: it owns one read-address port (`ra`) and consumes the matching read-data port (`rd`), while writeback keeps exclusive use of the write port.

## Interface
- `DATA_W`, default 64: register width.
- `ADDR_W`, default 5: register index width; the block covers 2^ADDR_W = 32 registers.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `first_reg`  in  ADDR_W: first index of the range; latched on an accepted `start`.
- `last_reg`  in  ADDR_W: last index of the range; latched on an accepted `start`.
- `abort`  in  1: synchronous cancel; effective in any non-IDLE state.
- `ra`  out  ADDR_W: regfile read address.
- `rd`  in  DATA_W: regfile read data (combinational from `ra`).
- `dout`  out  DATA_W: beat data.
- `dout_idx`  out  ADDR_W: register index of the beat.
- `dout_last`  out  1: marks the final beat.
- `dout_valid`  out  1: beat valid.
- `dout_ready`  in  1: sink accepts the beat.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse on normal completion.

## Operation
- States:
  - IDLE. `start`=1 → READ: latch the range, set `ra` = `first_reg`, clear the checksum.
  - READ. Capture `rd` into `dout`, `ra` into `dout_idx`, set `dout_valid`; → SEND.
  - SEND. Holds until `dout_valid && dout_ready`.
    - If `ra` ≠ last: `ra` = `ra`+1 (mod 32) → READ.
    - Else: → CSUM when the macro is defined, otherwise → DONE.
  - CSUM. Presents a single checksum beat; on handshake → DONE.
  - DONE. `done`=1 for one cycle → IDLE.
- Range wraps modulo 32. Beat count = ((last−first) mod 32)+1.
  - `first` = `last` gives exactly 1 beat.
  - `first` = `last`+1 gives all 32 beats.
- Index 31 (XZR) is dumped like any other register. The value streamed is whatever `rd` returns, i.e. 0.
- `dout_last` is high on the final beat only: the checksum beat when the macro is defined, otherwise the beat at `last_reg`.
- `start` while busy is ignored. Range inputs are ignored except on an accepted `start`.
- `abort` has priority over everything, including a same-cycle handshake. Next cycle: IDLE, `dout_valid`=0, no `done` pulse. A beat handshaken in the abort cycle counts as delivered.
- While `dout_valid`=1 and `dout_ready`=0, `dout`, `dout_idx`, `dout_last` and `ra` are held stable.

## Timing
- Reset (async assert, sync deassert by the system): state IDLE; `ra`, `dout`, `dout_idx` = 0; `dout_last`, `dout_valid`, `busy`, `done` = 0.
- Reset mid-dump aborts immediately; the same reset values apply.
- `start` sampled at edge N → `busy`=1 and `ra`=first after N. First `dout_valid` after edge N+1.
- With `dout_ready` tied high: one beat every 2 cycles (READ bubble). A k-beat dump is busy for 2k+1 cycles (+2 with the checksum).
- `done` is asserted the cycle after the final handshake. `busy` falls together with `done`.

## Configuration
- `REGFILE_DUMP_CHECKSUM_EN` defined:
  - A running DATA_W-bit wrapping sum of all dumped values is kept.
  - It is emitted as one extra beat with `dout_idx`=0 and `dout_last`=1.
- Not defined: no accumulator, no CSUM state; the last register beat carries `dout_last`.

## Test plan
Regfile preloaded X0..X30 = 0..30, X31 reads 0.
- `first`=0, `last`=3, `dout_ready`=1 → beats (idx, data) = (0,0) (1,1) (2,2) (3,3), `dout_last` on idx 3 (on the checksum beat value 6 if enabled), then `done` pulse.
- Wrap: `first`=29, `last`=1 → idx 29, 30, 31, 0, 1 with data 29, 30, 0, 0, 1; checksum 60.
- Backpressure: `dout_ready`=0 for 3 cycles on idx 2 of 0..3 → `dout`=2, `dout_idx`=2 stable; `ra` unchanged; stream then resumes.
- `abort` asserted while idx 5 of range 4..10 is valid → IDLE next cycle, `dout_valid`=0, `done` never pulses, `busy`=0.
- `reset_n` low during the SEND of idx 7 → all outputs 0 immediately; no further beats after release.
- `first`=`last`=31 → single beat data 0, `dout_last`=1 (without macro); `start` pulses during that dump are ignored.
